pwm_multi_channel: RTL and testbench

Parametrised multi-channel PWM generator. It is the successor to the single-channel fixed-period 0–99 PWM block. It drives CH outputs from one shared period counter with:
- a clock prescaler;
- edge-aligned or center-aligned modes;
- per-channel polarity;
- shadowed period and duty registers that update only at period boundaries, so outputs never glitch.

It sits between the control/register logic and the LED/driver pins.

---
 rtl/pwm_multi_channel.sv | 146 ++++++++++++++
 tb/tb_pwm_multi_channel.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM generator with shared prescaled period counter
//
// Ports:
//   clk          system clock, all logic on rising edge
//   rst          synchronous active-low reset
//   enable       global run; low holds counters at 0 and drives outputs to polarity
//   prescale     counter advances once every prescale+1 clocks (shadowed)
//   period       top count P (shadowed)
//   center       0 = edge-aligned, 1 = center-aligned (shadowed)
//   duty         packed duty values, channel i at [i*CW +: CW] (shadowed)
//   polarity     per-channel output inversion, applied live
//   load         request to commit prescale/period/center/duty into shadows
//   pwm_out      registered PWM outputs
//   cycle_start  one-clock pulse aligned with the first output of each period
//   load_ack     one-clock pulse one clock after the shadows are committed

module pwm_multi_channel #(
    parameter int CH = 4,
    parameter int CW = 8,
    parameter int PW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PW-1:0]    prescale,
    input  logic [CW-1:0]    period,
    input  logic             center,
    input  logic [CH*CW-1:0] duty,
    input  logic [CH-1:0]    polarity,
    input  logic             load,
    output logic [CH-1:0]    pwm_out,
    output logic             cycle_start,
    output logic             load_ack
);

    // counter state
    logic [PW-1:0]    pre_cnt;
    logic [CW-1:0]    cnt;
    logic             down;         // 0 = counting up, 1 = counting down (center mode)

    // shadow registers
    logic [PW-1:0]    ps_sh;
    logic [CW-1:0]    p_sh;
    logic             center_sh;
    logic [CH*CW-1:0] duty_sh;

    logic             pending;
    // Outputs lag cnt by one clock, so the period-start and commit events are
    // delayed one stage to line up with the first compare of the new period.
    logic             boundary_q;
    logic             commit_q;

    // combinational next-state
    logic             tick;
    logic [CW-1:0]    cnt_nxt;
    logic             down_nxt;
    logic             boundary;
    logic             pend_eff;
    logic             commit;
    logic [CH-1:0]    raw;

    always_comb begin
        tick     = enable && (pre_cnt == ps_sh);
        cnt_nxt  = cnt;
        down_nxt = down;

        if (center_sh && (p_sh != '0)) begin
            if (!down) begin
                if (cnt >= p_sh) begin
                    cnt_nxt  = cnt - 1'b1;
                    down_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end else begin
            // edge mode; center mode with P = 0 degenerates to this as well
            cnt_nxt  = (cnt >= p_sh) ? '0 : cnt + 1'b1;
            down_nxt = 1'b0;
        end

        // reaching 0 always starts a fresh up-count (also covers P = 1 in center mode)
        if (cnt_nxt == '0) begin
            down_nxt = 1'b0;
        end

        boundary = tick && (cnt_nxt == '0);
        pend_eff = pending || load;
        // while disabled nothing runs, so a pending load commits immediately
        commit   = pend_eff && (!enable || boundary);

        for (int i = 0; i < CH; i++) begin
            raw[i] = (cnt < duty_sh[i*CW +: CW]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            down        <= 1'b0;
            ps_sh       <= '0;
            p_sh        <= '0;
            center_sh   <= 1'b0;
            duty_sh     <= '0;
            pending     <= 1'b0;
            boundary_q  <= 1'b0;
            commit_q    <= 1'b0;
            pwm_out     <= '0;
            cycle_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            pending <= pend_eff && !commit;

            // inputs are sampled on the commit clock, not the load clock
            if (commit) begin
                ps_sh     <= prescale;
                p_sh      <= period;
                center_sh <= center;
                duty_sh   <= duty;
            end

            if (!enable) begin
                pre_cnt <= '0;
                cnt     <= '0;
                down    <= 1'b0;
            end else if (tick) begin
                pre_cnt <= '0;
                cnt     <= cnt_nxt;
                down    <= down_nxt;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            boundary_q  <= boundary;
            commit_q    <= commit;
            cycle_start <= boundary_q && enable;
            load_ack    <= commit_q;

            pwm_out <= enable ? (raw ^ polarity) : polarity;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard testbench for pwm_multi_channel

module tb_pwm_multi_channel;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int PW = 16;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [PW-1:0]    prescale;
    logic [CW-1:0]    period;
    logic             center;
    logic [CH*CW-1:0] duty;
    logic [CH-1:0]    polarity;
    logic             load;
    logic [CH-1:0]    pwm_out;
    logic             cycle_start;
    logic             load_ack;

    pwm_multi_channel #(.CH(CH), .CW(CW), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .prescale   (prescale),
        .period     (period),
        .center     (center),
        .duty       (duty),
        .polarity   (polarity),
        .load       (load),
        .pwm_out    (pwm_out),
        .cycle_start(cycle_start),
        .load_ack   (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          cs;
        logic          ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    // ---------------- reference model ----------------
    // Position inside the period is tracked as clocks since the period started;
    // the counter value is derived arithmetically from it.
    int m_pos    = 0;
    int m_ps     = 0;
    int m_p      = 0;
    bit m_center = 0;
    int m_d[CH];
    bit m_pend   = 0;
    bit m_pcs    = 0;
    bit m_pack   = 0;

    function automatic bit m_is_center();
        return m_center && (m_p != 0);
    endfunction

    function automatic int m_len();
        if (m_is_center()) return 2 * m_p * (m_ps + 1);
        return (m_p + 1) * (m_ps + 1);
    endfunction

    function automatic int m_cnt();
        int k;
        k = m_pos / (m_ps + 1);
        if (m_is_center() && (k > m_p)) return 2 * m_p - k;
        return k;
    endfunction

    task automatic m_commit();
        m_ps     = int'(prescale);
        m_p      = int'(period);
        m_center = center;
        for (int i = 0; i < CH; i++) m_d[i] = int'(duty[i*CW +: CW]);
        m_pend = 0;
        m_pack = 1;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < CH; i++) m_d[i] = 0;
        forever begin
            @(posedge clk);
            n_cycle++;
            if (!rst) begin
                e = '0;
                m_pos = 0; m_ps = 0; m_p = 0; m_center = 0;
                for (int i = 0; i < CH; i++) m_d[i] = 0;
                m_pend = 0; m_pcs = 0; m_pack = 0;
            end else begin
                for (int i = 0; i < CH; i++) begin
                    e.pwm[i] = enable ? ((m_cnt() < m_d[i]) ^ polarity[i]) : polarity[i];
                end
                e.cs  = m_pcs && enable;
                e.ack = m_pack;
                m_pcs  = 0;
                m_pack = 0;
                if (load) m_pend = 1;
                if (!enable) begin
                    m_pos = 0;
                    if (m_pend) m_commit();
                end else begin
                    m_pos++;
                    if (m_pos >= m_len()) begin
                        m_pos = 0;
                        m_pcs = 1;
                        if (m_pend) m_commit();
                    end
                end
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (pwm_out !== e.pwm) begin
                    n_fail++;
                    $display("FAIL pwm_out cycle %0d: got %b expected %b", n_cycle, pwm_out, e.pwm);
                end
                n_checks++;
                if (cycle_start !== e.cs) begin
                    n_fail++;
                    $display("FAIL cycle_start cycle %0d: got %b expected %b", n_cycle, cycle_start, e.cs);
                end
                n_checks++;
                if (load_ack !== e.ack) begin
                    n_fail++;
                    $display("FAIL load_ack cycle %0d: got %b expected %b", n_cycle, load_ack, e.ack);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        bit got;
        got  = 0;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            step();
            if (load_ack === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL load_ack_timeout: got no ack within 3000 cycles, required an ack");
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 99) < 8) polarity = CH'($urandom);
            // unloaded duty changes must never reach the outputs
            if ($urandom_range(0, 99) < 5) duty = (CH*CW)'({$urandom, $urandom});
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            step();
        end
    endtask

    task automatic set_duty(input int ch, input int v);
        duty[ch*CW +: CW] = CW'(v);
    endtask

    task automatic rand_cfg();
        prescale = PW'($urandom_range(0, 3));
        period   = CW'($urandom_range(0, 12));
        center   = 1'($urandom_range(0, 1));
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 9))
                0:       set_duty(i, 0);
                1:       set_duty(i, 255);
                default: set_duty(i, $urandom_range(0, int'(period) + 1));
            endcase
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; prescale = '0; period = '0; center = 1'b0;
        duty = '0; polarity = '0; load = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // edge mode, P=9, duties {0,3,10,255}
        prescale = 16'd0; period = 8'd9; center = 1'b0;
        duty = {8'd255, 8'd10, 8'd3, 8'd0};
        do_load();
        enable = 1'b1;
        repeat (40) step();

        // prescaler: PS=2, P=4, duty[1]=2 (load while running)
        prescale = 16'd2; period = 8'd4; set_duty(1, 2);
        do_load();
        repeat (60) step();

        // center: P=4, duty[0]=2
        prescale = 16'd0; period = 8'd4; center = 1'b1; set_duty(0, 2);
        do_load();
        repeat (40) step();

        // shadowing: duty[1] 3 -> 7 requested mid-period
        center = 1'b0; period = 8'd9; set_duty(1, 3);
        do_load();
        repeat (14) step();
        set_duty(1, 7);
        do_load();
        repeat (30) step();

        // enable low with polarity, load while disabled, then re-enable
        polarity = 4'b0101; enable = 1'b0;
        repeat (5) step();
        set_duty(2, 5); period = 8'd6;
        do_load();
        enable = 1'b1;
        repeat (30) step();
        polarity = 4'b0000;

        // randomized configurations
        for (int it = 0; it < 25; it++) begin
            rand_cfg();
            if ($urandom_range(0, 3) == 0) enable = 1'b0;
            do_load();
            enable = 1'b1;
            run($urandom_range(20, 150));
        end

        // reset mid-period with a load pending
        enable = 1'b1; center = 1'b0; prescale = 16'd3; period = 8'd12;
        duty = {8'd1, 8'd2, 8'd3, 8'd4};
        do_load();
        repeat (7) step();
        set_duty(0, 9);
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1; polarity = 4'b0011;
        repeat (20) step();

        repeat (2) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
